// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive-side controller and its frame FIFO.
// A frame entry packs the framing-error bit above the data byte.
package uart_pkg;

   localparam int UART_DATA_W  = 8;
   localparam int UART_ENTRY_W = UART_DATA_W + 1;

   typedef enum logic [1:0] {
      ST_OFF     = 2'd0,
      ST_ON      = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_ILLEGAL = 2'd3
   } uart_state_e;

   typedef struct packed {
      logic                   err;
      logic [UART_DATA_W-1:0] data;
   } uart_frame_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Parameterised show-ahead synchronous FIFO with flush and exact occupancy count.
// The head entry is presented combinationally from storage; it reads as zero when empty.
module uart_sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 9
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign count = count_q;
   assign rdata = empty ? '0 : mem_q[rd_ptr_q];

   // A push into a full FIFO is only honoured when a pop frees the slot in the same cycle.
   assign do_push = push & ~flush & (~full | pop);
   assign do_pop  = pop  & ~flush & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: gates the receiver baud enable, qualifies and queues frames,
// and keeps sticky overrun plus saturating framing-error and overrun counters.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          cfg_enable,
   input  logic                          cfg_drop_err,
   input  logic                          flush,
   input  logic                          clr_status,
   input  logic                          rx_enb_in,
   output logic                          rx_enb_gated,
   input  logic [UART_DATA_W-1:0]        rx_data,
   input  logic                          rx_done,
   input  logic                          error_flag,
   output logic [UART_DATA_W-1:0]        m_data,
   output logic                          m_err,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overrun,
   output logic [CNT_W-1:0]              ferr_cnt,
   output logic [CNT_W-1:0]              ovr_cnt,
   output logic [1:0]                    state_o
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   uart_state_e      state_q, state_d;
   logic [CNT_W-1:0] ferr_cnt_q, ferr_cnt_d;
   logic [CNT_W-1:0] ovr_cnt_q, ovr_cnt_d;
   logic             overrun_q, overrun_d;

   uart_frame_t      push_frame;
   uart_frame_t      head_frame;
   logic             fifo_full;
   logic             fifo_empty;
   logic             frame_s;
   logic             ferr_inc;
   logic             store_req;
   logic             pop_s;
   logic             drop_full;

   assign frame_s    = rx_done & (state_q == ST_ON);
   assign ferr_inc   = frame_s & error_flag;
   assign store_req  = frame_s & ~(error_flag & cfg_drop_err);
   assign pop_s      = ~fifo_empty & m_ready;
   assign drop_full  = store_req & fifo_full & ~pop_s;
   assign push_frame = '{err: error_flag, data: rx_data};

   uart_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .push  (store_req),
      .wdata (push_frame),
      .pop   (pop_s),
      .flush (flush),
      .rdata (head_frame),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign m_data       = head_frame.data;
   assign m_err        = head_frame.err;
   assign m_valid      = ~fifo_empty;
   assign rx_enb_gated = rx_enb_in & (state_q == ST_ON);
   assign state_o      = state_q;
   assign overrun      = overrun_q;
   assign ferr_cnt     = ferr_cnt_q;
   assign ovr_cnt      = ovr_cnt_q;

   // Re-enable wins over the drain-complete exit so a quick toggle never bounces through OFF.
   always_comb begin
      state_d = ST_OFF;
      case (state_q)
         ST_OFF:   state_d = cfg_enable ? ST_ON : ST_OFF;
         ST_ON:    state_d = cfg_enable ? ST_ON : ST_DRAIN;
         ST_DRAIN: begin
            if (cfg_enable)              state_d = ST_ON;
            else if (fifo_empty || flush) state_d = ST_OFF;
            else                         state_d = ST_DRAIN;
         end
         default:  state_d = ST_OFF;
      endcase
   end

   // Counters still see events in a flush cycle; a clear in the same cycle overrides them.
   always_comb begin
      ferr_cnt_d = ferr_cnt_q;
      ovr_cnt_d  = ovr_cnt_q;
      overrun_d  = overrun_q;
      if (ferr_inc && (ferr_cnt_q != '1)) ferr_cnt_d = ferr_cnt_q + CNT_ONE;
      if (drop_full) begin
         overrun_d = 1'b1;
         if (ovr_cnt_q != '1) ovr_cnt_d = ovr_cnt_q + CNT_ONE;
      end
      if (clr_status) begin
         ferr_cnt_d = '0;
         ovr_cnt_d  = '0;
         overrun_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_OFF;
         ferr_cnt_q <= '0;
         ovr_cnt_q  <= '0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ferr_cnt_q <= ferr_cnt_d;
         ovr_cnt_q  <= ovr_cnt_d;
         overrun_q  <= overrun_d;
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_rx_ctrl;

   localparam int DEPTH = 8;
   localparam int CW    = 8;
   localparam int CMAX  = (1 << CW) - 1;

   logic       clk = 1'b0;
   logic       reset;
   logic       cfg_enable, cfg_drop_err, flush, clr_status, rx_enb_in;
   logic       rx_enb_gated;
   logic [7:0] rx_data;
   logic       rx_done, error_flag;
   logic [7:0] m_data;
   logic       m_err, m_valid, m_ready;
   logic [3:0] fifo_count;
   logic       overrun;
   logic [7:0] ferr_cnt, ovr_cnt;
   logic [1:0] state_o;

   int n_pass  = 0;
   int n_total = 0;
   bit chk_on  = 1'b0;

   // reference model state
   logic [8:0] mq[$];
   int         mst, mferr, movr;
   bit         movf;

   always #5 clk = ~clk;

   uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .cfg_enable(cfg_enable), .cfg_drop_err(cfg_drop_err),
      .flush(flush), .clr_status(clr_status), .rx_enb_in(rx_enb_in),
      .rx_enb_gated(rx_enb_gated), .rx_data(rx_data), .rx_done(rx_done),
      .error_flag(error_flag), .m_data(m_data), .m_err(m_err), .m_valid(m_valid),
      .m_ready(m_ready), .fifo_count(fifo_count), .overrun(overrun),
      .ferr_cnt(ferr_cnt), .ovr_cnt(ovr_cnt), .state_o(state_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      mq.delete();
      mst = 0; mferr = 0; movr = 0; movf = 1'b0;
   endtask

   task automatic model_step();
      int sz;
      bit frame, pop, store, full;
      if (!reset) begin
         model_reset();
         return;
      end
      sz    = mq.size();
      frame = rx_done && (mst == 1);
      pop   = (sz > 0) && m_ready;
      store = frame && !(error_flag && cfg_drop_err);
      full  = (sz == DEPTH);
      if (frame && error_flag && mferr < CMAX) mferr++;
      if (store && full && !pop) begin
         if (movr < CMAX) movr++;
         movf = 1'b1;
      end
      if (flush) mq.delete();
      else begin
         if (pop) void'(mq.pop_front());
         if (store && (!full || pop)) mq.push_back({error_flag, rx_data});
      end
      if (clr_status) begin
         mferr = 0; movr = 0; movf = 1'b0;
      end
      case (mst)
         0:       mst = cfg_enable ? 1 : 0;
         1:       mst = cfg_enable ? 1 : 2;
         default: mst = cfg_enable ? 1 : ((sz == 0 || flush) ? 0 : 2);
      endcase
   endtask

   // every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (chk_on) begin
         check("m_valid",    {31'd0, m_valid},   {31'd0, mq.size() > 0});
         check("m_data",     {24'd0, m_data},    (mq.size() > 0) ? {24'd0, mq[0][7:0]} : 32'd0);
         check("m_err",      {31'd0, m_err},     (mq.size() > 0) ? {31'd0, mq[0][8]} : 32'd0);
         check("fifo_count", {28'd0, fifo_count}, mq.size());
         check("overrun",    {31'd0, overrun},   {31'd0, movf});
         check("ferr_cnt",   {24'd0, ferr_cnt},  mferr);
         check("ovr_cnt",    {24'd0, ovr_cnt},   movr);
         check("state",      {30'd0, state_o},   mst);
         check("rx_enb_gated", {31'd0, rx_enb_gated}, {31'd0, rx_enb_in && (mst == 1)});
      end
   end

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic push_frame(input logic [7:0] d, input logic e);
      rx_data = d; error_flag = e; rx_done = 1'b1;
      tick();
      rx_done = 1'b0; error_flag = 1'b0;
   endtask

   initial begin
      reset = 1'b0; cfg_enable = 1'b0; cfg_drop_err = 1'b0; flush = 1'b0;
      clr_status = 1'b0; rx_enb_in = 1'b0; rx_data = '0; rx_done = 1'b0;
      error_flag = 1'b0; m_ready = 1'b0;
      model_reset();
      #1;
      chk_on = 1'b1;
      repeat (3) tick();
      check("rst_state", {30'd0, state_o}, 0);
      check("rst_valid", {31'd0, m_valid}, 0);
      check("rst_count", {28'd0, fifo_count}, 0);
      reset = 1'b1;

      // basic path
      cfg_enable = 1'b1; rx_enb_in = 1'b1; m_ready = 1'b1;
      tick();
      check("on_state", {30'd0, state_o}, 1);
      check("on_gate", {31'd0, rx_enb_gated}, 1);
      push_frame(8'hA5, 1'b0);
      check("basic_valid", {31'd0, m_valid}, 1);
      check("basic_data", {24'd0, m_data}, 32'hA5);
      check("basic_err", {31'd0, m_err}, 0);
      tick();
      check("basic_popped", {28'd0, fifo_count}, 0);

      // framing errors: stored, then dropped
      m_ready = 1'b0;
      push_frame(8'h3C, 1'b1);
      check("ferr_err", {31'd0, m_err}, 1);
      check("ferr_data", {24'd0, m_data}, 32'h3C);
      check("ferr_cnt1", {24'd0, ferr_cnt}, 1);
      m_ready = 1'b1; tick(); m_ready = 1'b0;
      cfg_drop_err = 1'b1;
      push_frame(8'h3C, 1'b1);
      check("drop_count", {28'd0, fifo_count}, 0);
      check("ferr_cnt2", {24'd0, ferr_cnt}, 2);
      cfg_drop_err = 1'b0;

      // overrun
      for (int i = 1; i <= 9; i++) push_frame(8'(i), 1'b0);
      check("ovr_count", {28'd0, fifo_count}, 8);
      check("ovr_flag", {31'd0, overrun}, 1);
      check("ovr_cnt", {24'd0, ovr_cnt}, 1);
      check("ovr_head", {24'd0, m_data}, 1);
      m_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         check("ovr_order", {24'd0, m_data}, i);
         tick();
      end
      m_ready = 1'b0;
      check("ovr_empty", {28'd0, fifo_count}, 0);

      // full with simultaneous push and pop
      clr_status = 1'b1; tick(); clr_status = 1'b0;
      for (int i = 0; i < 8; i++) push_frame(8'(8'h10 + i), 1'b0);
      m_ready = 1'b1;
      push_frame(8'h55, 1'b0);
      check("fpp_count", {28'd0, fifo_count}, 8);
      check("fpp_ovr", {31'd0, overrun}, 0);
      check("fpp_ovrcnt", {24'd0, ovr_cnt}, 0);
      for (int i = 1; i < 8; i++) begin
         check("fpp_order", {24'd0, m_data}, 32'h10 + i);
         tick();
      end
      check("fpp_last", {24'd0, m_data}, 32'h55);
      tick();
      m_ready = 1'b0;

      // drain and gating
      for (int i = 0; i < 3; i++) push_frame(8'(8'h61 + i), 1'b0);
      cfg_enable = 1'b0;
      tick();
      check("drain_state", {30'd0, state_o}, 2);
      rx_enb_in = 1'b1; #1;
      check("drain_gate", {31'd0, rx_enb_gated}, 0);
      push_frame(8'h77, 1'b0);
      check("drain_ignore", {28'd0, fifo_count}, 3);
      m_ready = 1'b1;
      repeat (3) tick();
      check("drain_empty", {28'd0, fifo_count}, 0);
      tick();
      check("drain_off", {30'd0, state_o}, 0);
      m_ready = 1'b0;

      // framing-error counter saturation
      cfg_enable = 1'b1; tick();
      cfg_drop_err = 1'b1; error_flag = 1'b1; rx_done = 1'b1;
      repeat (260) tick();
      rx_done = 1'b0; error_flag = 1'b0; cfg_drop_err = 1'b0;
      check("ferr_sat", {24'd0, ferr_cnt}, 255);

      // flush and clear
      for (int i = 0; i < 5; i++) push_frame(8'(8'h80 + i), 1'b0);
      check("pre_flush", {28'd0, fifo_count}, 5);
      flush = 1'b1; tick(); flush = 1'b0;
      check("flush_count", {28'd0, fifo_count}, 0);
      check("flush_valid", {31'd0, m_valid}, 0);
      clr_status = 1'b1;
      push_frame(8'hE1, 1'b1);
      clr_status = 1'b0;
      check("clr_ferr", {24'd0, ferr_cnt}, 0);

      // asynchronous reset with data queued
      push_frame(8'h42, 1'b0);
      reset = 1'b0; #1;
      model_reset();
      check("arst_valid", {31'd0, m_valid}, 0);
      check("arst_count", {28'd0, fifo_count}, 0);
      check("arst_state", {30'd0, state_o}, 0);
      check("arst_data", {24'd0, m_data}, 0);
      check("arst_gate", {31'd0, rx_enb_gated}, 0);
      repeat (2) tick();
      reset = 1'b1;

      // randomized traffic with phase-varying back-pressure
      for (int n = 0; n < 4000; n++) begin
         int rdy_pct;
         rdy_pct = ((n / 400) % 3 == 0) ? 15 : (((n / 400) % 3 == 1) ? 50 : 90);
         if (!reset) reset = 1'b1;
         else if ($urandom_range(0, 999) < 3) begin
            reset = 1'b0; #1;
            model_reset();
         end
         if ($urandom_range(0, 99) < 4) cfg_enable = ~cfg_enable;
         if ($urandom_range(0, 99) < 2) cfg_drop_err = ~cfg_drop_err;
         flush      = ($urandom_range(0, 99) < 2);
         clr_status = ($urandom_range(0, 99) < 2);
         rx_enb_in  = 1'($urandom_range(0, 1));
         rx_done    = ($urandom_range(0, 99) < 45);
         error_flag = ($urandom_range(0, 99) < 25);
         rx_data    = 8'($urandom_range(0, 255));
         m_ready    = ($urandom_range(0, 99) < rdy_pct);
         tick();
      end

      @(negedge clk);
      chk_on = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
